// File: rtl/e203_bht_upd_sched.sv
// e203_bht_upd_sched: arbitrates the single BHT port between IFU lookups and
// queued branch-resolution updates. Each update is a two-cycle
// read-modify-write of the 2-bit counter (RD, then WR) with an optional
// target write.
// The IFU has priority unless it has starved the queue for STARVE_MAX grants.
// Optional build macro: E203_BHT_UPD_MISONLY_EN -- when defined, only
// mispredicting updates are queued and the others are accepted and dropped.
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module e203_bht_upd_sched #(
  parameter int BHT_IDX_W  = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [`E203_PC_SIZE-1:0]  upd_pc,
  input  logic                      upd_rslv,
  input  logic                      upd_mis,
  input  logic [`E203_PC_SIZE-1:0]  upd_tgt,
  input  logic                      ifu_rd_req,
  input  logic [BHT_IDX_W-1:0]      ifu_rd_idx,
  output logic                      ifu_rd_gnt,
  output logic                      bht_en,
  output logic                      bht_we,
  output logic [BHT_IDX_W-1:0]      bht_idx,
  output logic [1:0]                bht_wcnt,
  output logic                      bht_wtgt_en,
  output logic [`E203_PC_SIZE-1:0]  bht_wtgt,
  input  logic [1:0]                bht_rcnt,
  output logic                      sched_busy
);

  localparam int PC_W  = `E203_PC_SIZE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

  state_t               state_reg, state_next;
  logic [BHT_IDX_W-1:0] q_idx  [FIFO_DEPTH];
  logic                 q_rslv [FIFO_DEPTH];
  logic [PC_W-1:0]      q_tgt  [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_reg, rptr_reg;
  logic [PTR_W:0]       count_reg;
  logic [CNT_W-1:0]     starve_reg;

  logic                 full, empty, force_upd, accept, push, pop;
  logic [BHT_IDX_W-1:0] head_idx;
  logic                 head_rslv;
  logic [PC_W-1:0]      head_tgt;
  logic [1:0]           sat_cnt;

  // Raw (pre-reset-gating) port values from the FSM decode
  logic                 gnt_c, en_c, we_c, wtgt_en_c;
  logic [BHT_IDX_W-1:0] idx_c;
  logic [1:0]           wcnt_c;
  logic [PC_W-1:0]      wtgt_c;

  // PC bit 0 and bits above the index never select a BHT entry
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_mis, upd_pc[0], upd_pc[PC_W-1:BHT_IDX_W+1]};

  assign full      = (count_reg == DEPTH_CNT);
  assign empty     = (count_reg == '0);
  assign force_upd = (starve_reg == STARVE_LIM);
  assign head_idx  = q_idx[rptr_reg];
  assign head_rslv = q_rslv[rptr_reg];
  assign head_tgt  = q_tgt[rptr_reg];

  // Ready depends on stored occupancy only, so a pop in the same cycle
  // never opens a slot for a full queue.
  assign upd_ready = rst_n & ~full;
  assign accept    = upd_valid & upd_ready;
`ifdef E203_BHT_UPD_MISONLY_EN
  assign push      = accept & upd_mis;
`else
  assign push      = accept;
`endif
  assign pop       = (state_reg == ST_WR);

  // Saturating 2-bit counter step toward the resolved direction
  always_comb begin
    sat_cnt = bht_rcnt;
    if (head_rslv) begin
      if (bht_rcnt != 2'd3) sat_cnt = bht_rcnt + 2'd1;
    end else begin
      if (bht_rcnt != 2'd0) sat_cnt = bht_rcnt - 2'd1;
    end
  end

  // Next-state and BHT port decode; every output idles at 0 by default
  always_comb begin
    state_next = state_reg;
    gnt_c      = 1'b0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    idx_c      = '0;
    wcnt_c     = 2'd0;
    wtgt_en_c  = 1'b0;
    wtgt_c     = '0;
    case (state_reg)
      ST_IDLE: begin
        gnt_c = ifu_rd_req & ~force_upd;
        if (gnt_c) begin
          en_c  = 1'b1;
          idx_c = ifu_rd_idx;
        end
        if (!empty && (!ifu_rd_req || force_upd)) state_next = ST_RD;
      end
      ST_RD: begin
        en_c       = 1'b1;
        idx_c      = head_idx;
        state_next = ST_WR;
      end
      ST_WR: begin
        en_c       = 1'b1;
        we_c       = 1'b1;
        idx_c      = head_idx;
        wcnt_c     = sat_cnt;
        wtgt_en_c  = head_rslv;
        wtgt_c     = head_tgt;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Hold every output low while reset is asserted
  assign ifu_rd_gnt  = rst_n & gnt_c;
  assign bht_en      = rst_n & en_c;
  assign bht_we      = rst_n & we_c;
  assign bht_idx     = rst_n ? idx_c : '0;
  assign bht_wcnt    = rst_n ? wcnt_c : 2'd0;
  assign bht_wtgt_en = rst_n & wtgt_en_c;
  assign bht_wtgt    = rst_n ? wtgt_c : '0;
  assign sched_busy  = rst_n & (~empty | (state_reg != ST_IDLE));

  // FSM state register; reset abandons any RMW in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Queue payload storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wptr_reg]  <= upd_pc[BHT_IDX_W:1];
      q_rslv[wptr_reg] <= upd_rslv;
      q_tgt[wptr_reg]  <= upd_tgt;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + 1'b1;
      if (pop)  rptr_reg <= rptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Count IFU wins against a waiting update; cleared when the update starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
    end else if (state_reg == ST_IDLE && state_next == ST_RD) begin
      starve_reg <= '0;
    end else if (state_reg == ST_IDLE && !empty && gnt_c && starve_reg != STARVE_LIM) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

endmodule
